// File: rtl/redux_pool.sv
// redux_pool: 2x2 pixel pooling stage (mean/rounded mean/min/max) with a registered valid/ready output
module redux_pool #(
  parameter int PIX_W = 8,
  parameter int MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*PIX_W-1:0] in_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pix
);
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("redux_pool: illegal MODE %0d", MODE);
  end
  logic [PIX_W-1:0] a, b, c, d, mean, mn_ab, mn_cd, mx_ab, mx_cd, res;
  logic [1:0] frac;
  logic unused;
  assign a = in_pix[PIX_W-1:0];
  assign b = in_pix[2*PIX_W-1:PIX_W];
  assign c = in_pix[3*PIX_W-1:2*PIX_W];
  assign d = in_pix[4*PIX_W-1:3*PIX_W];
  assign {mean, frac} = {2'b0, a} + {2'b0, b} + {2'b0, c} + {2'b0, d} + (PIX_W+2)'(MODE == 1 ? 2 : 0);
  assign unused = ^frac;
  assign mn_ab = a < b ? a : b;
  assign mn_cd = c < d ? c : d;
  assign mx_ab = a > b ? a : b;
  assign mx_cd = c > d ? c : d;
  always_comb begin
    res = mean;
    if (MODE == 2) res = mn_ab < mn_cd ? mn_ab : mn_cd;
    if (MODE == 3) res = mx_ab > mx_cd ? mx_ab : mx_cd;
  end
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pix <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_pix <= res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_redux_pool.sv
// tb_redux_pool: scoreboard bench running all four reduction modes side by side against an arithmetic model
module tb_redux_pool;
  logic clk, rst, in_valid, out_ready;
  logic [31:0] in_pix;
  logic ir [4];
  logic ov [4];
  logic [7:0] op [4];
  int compared = 0, mismatched = 0, accepts = 0, pops = 0;
  logic [31:0] exp_q [$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_op [4];
  for (genvar m = 0; m < 4; m++) begin : g_dut
    redux_pool #(.PIX_W(8), .MODE(m)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[m]), .in_pix(in_pix),
      .out_valid(ov[m]), .out_ready(out_ready), .out_pix(op[m])
    );
  end
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic logic [7:0] model(input int mode, input logic [31:0] p);
    int s = 0, mn = 255, mx = 0, v;
    for (int i = 0; i < 4; i++) begin
      v = int'(p[8*i +: 8]);
      s += v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    case (mode)
      0: return 8'(s / 4);
      1: return 8'((s + 2) / 4);
      2: return 8'(mn);
      default: return 8'(mx);
    endcase
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (in_valid && ir[0]) begin
      exp_q.push_back({model(3, in_pix), model(2, in_pix), model(1, in_pix), model(0, in_pix)});
      accepts++;
    end
  end
  always @(negedge clk) begin
    logic [31:0] e;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("in_ready_m%0d", m), int'(ir[m]), int'(!ov[m] || out_ready));
      if (prev_stall) begin
        chk($sformatf("stall_valid_m%0d", m), int'(ov[m]), 1);
        chk($sformatf("stall_pix_m%0d", m), int'(op[m]), int'(prev_op[m]));
      end
    end
    if (ov[0] && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        pops++;
        for (int m = 0; m < 4; m++) begin
          chk($sformatf("valid_m%0d", m), int'(ov[m]), 1);
          chk($sformatf("pix_m%0d", m), int'(op[m]), int'(e[8*m +: 8]));
        end
      end
    end
    prev_stall = ov[0] && !out_ready && !rst;
    for (int m = 0; m < 4; m++) prev_op[m] = op[m];
  end
  task automatic cyc(input logic v, input logic [31:0] p, input logic r);
    in_valid = v;
    in_pix = p;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cleared(input string name);
    for (int m = 0; m < 4; m++) begin
      chk({name, $sformatf("_valid_m%0d", m)}, int'(ov[m]), 0);
      chk({name, $sformatf("_pix_m%0d", m)}, int'(op[m]), 0);
    end
  endtask
  initial begin
    int a0;
    logic [31:0] dir [4];
    dir = '{32'h80808080, 32'hFFFFFFFF, 32'h00000000, 32'h04030201};
    rst = 1;
    in_valid = 0;
    in_pix = 0;
    out_ready = 1;
    repeat (3) cyc(1, $urandom, 1);
    chk_cleared("reset");
    for (int m = 0; m < 4; m++) chk($sformatf("reset_ready_m%0d", m), int'(ir[m]), 1);
    rst = 0;
    foreach (dir[i]) cyc(1, dir[i], 1);
    chk("mode0_04030201", int'(op[0]), 8'h02);
    chk("mode1_04030201", int'(op[1]), 8'h03);
    chk("mode2_04030201", int'(op[2]), 8'h01);
    chk("mode3_04030201", int'(op[3]), 8'h04);
    cyc(0, $urandom, 1);
    a0 = accepts;
    for (int i = 0; i < 3000; i++) cyc(1, $urandom, 1);
    chk("burst_accepts", accepts - a0, 3000);
    cyc(1, $urandom, 0);
    repeat (5) cyc(1, $urandom, 0);
    cyc(0, $urandom, 1);
    for (int i = 0; i < 1000; i++) cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
    cyc(1, 32'hFFFFFFFF, 0);
    rst = 1;
    cyc(1, 32'h12345678, 0);
    chk_cleared("midreset");
    rst = 0;
    for (int i = 0; i < 500; i++) cyc($urandom_range(0, 1) != 0, $urandom, $urandom_range(0, 3) != 0);
    repeat (4) cyc(0, $urandom, 1);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", int'(ov[0]), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
